// File: rtl/inst_aligner_pkg.sv
// rtl/inst_aligner_pkg.sv - shared types and helpers for the instruction aligner
//
// Contents:
//   align_state_e : aligner leftover-halfword state (EMPTY / HALF / SKIP)
//   fetch_word_t  : one fetch beat (data, word address, bus error)
//   is_rvc()      : true when a halfword starts a 16-bit compressed instruction
package inst_aligner_pkg;

    localparam int ALIGN_XLEN = 32;

    typedef enum logic [1:0] {
        ALIGN_EMPTY = 2'd0,
        ALIGN_HALF  = 2'd1,
        ALIGN_SKIP  = 2'd2
    } align_state_e;

    typedef struct packed {
        logic [31:0]           data;
        logic [ALIGN_XLEN-1:0] pc;
        logic                  err;
    } fetch_word_t;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/inst_aligner_skid.sv
// rtl/inst_aligner_skid.sv - generic valid/ready skid buffer for the aligner output
//
// Only compiled when ALIGN_SKID_EN is defined.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear_i               : drop both entries (redirect)
//   in_valid_i/in_ready_o : upstream handshake; in_ready_o is a pure flop output
//   in_data_i             : upstream payload
//   out_valid_o/out_ready_i/out_data_o : registered downstream handshake
`ifdef ALIGN_SKID_EN
module inst_aligner_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Ready only looks at the spare slot, so no path from out_ready_i.
    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_valid_q ? out_data_q : '0;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (clear_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_ready_i || !out_valid_q) begin
            // Output slot frees up: the spare entry is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule
`endif

// File: rtl/inst_aligner.sv
// rtl/inst_aligner.sv - splits 32-bit fetch words into RVC / 32-bit instructions for decode
//
// Optional feature macro: ALIGN_SKID_EN (registered inst_* outputs via inst_aligner_skid).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush_i, flush_pc_i        : redirect; bit 1 of the PC selects the starting halfword
//   fetch_valid_i/fetch_ready_o: fetch word handshake
//   fetch_data_i, fetch_pc_i   : fetch word (little-endian halfwords) and its word address
//   fetch_err_i                : bus error on this fetch word
//   inst_valid_o/inst_ready_i  : instruction handshake to decode
//   inst_o, inst_pc_o          : instruction (RVC zero-extended) and its PC
//   inst_is_rvc_o, inst_err_o  : compressed flag, fetch error flag
module inst_aligner
    import inst_aligner_pkg::*;
#(
    parameter int              XLEN     = ALIGN_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic            fetch_err_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_is_rvc_o,
    output logic            inst_err_o
);

    localparam logic [XLEN-1:0] PC_TWO = XLEN'(2);

    align_state_e    state_q, state_d;
    logic [15:0]     hw_q, hw_d;
    logic [XLEN-1:0] hw_pc_q, hw_pc_d;
    logic            hw_err_q, hw_err_d;
    // Set after an errored word was handed to decode; only a flush clears it.
    logic            halt_q, halt_d;

    logic            core_valid;
    logic            core_ready;
    logic [31:0]     core_inst;
    logic [XLEN-1:0] core_pc;
    logic            core_err;

    fetch_word_t     fw;
    logic [15:0]     lo_hw;
    logic [15:0]     hi_hw;
    logic [XLEN-1:0] pc_plus2;
    logic            unused_flush_lsb;

    assign fw               = '{data: fetch_data_i, pc: fetch_pc_i, err: fetch_err_i};
    assign lo_hw            = fw.data[15:0];
    assign hi_hw            = fw.data[31:16];
    assign pc_plus2         = fw.pc + PC_TWO;
    assign unused_flush_lsb = flush_pc_i[0];

    always_comb begin
        state_d       = state_q;
        hw_d          = hw_q;
        hw_pc_d       = hw_pc_q;
        hw_err_d      = hw_err_q;
        halt_d        = halt_q;
        core_valid    = 1'b0;
        core_inst     = '0;
        core_pc       = '0;
        core_err      = 1'b0;
        fetch_ready_o = 1'b0;

        if (flush_i) begin
            state_d  = flush_pc_i[1] ? ALIGN_SKIP : ALIGN_EMPTY;
            hw_d     = '0;
            hw_err_d = 1'b0;
            hw_pc_d  = {flush_pc_i[XLEN-1:1], 1'b0};
            halt_d   = 1'b0;
        end else if (!halt_q) begin
            unique case (state_q)
                ALIGN_EMPTY: begin
                    fetch_ready_o = !fetch_valid_i || core_ready;
                    if (fetch_valid_i) begin
                        core_valid = 1'b1;
                        core_pc    = fw.pc;
                        if (fw.err) begin
                            core_inst = fw.data;
                            core_err  = 1'b1;
                            if (core_ready) begin
                                halt_d = 1'b1;
                            end
                        end else if (is_rvc(lo_hw)) begin
                            core_inst = {16'h0000, lo_hw};
                            if (core_ready) begin
                                state_d  = ALIGN_HALF;
                                hw_d     = hi_hw;
                                hw_pc_d  = pc_plus2;
                                hw_err_d = 1'b0;
                            end
                        end else begin
                            core_inst = fw.data;
                        end
                    end
                end

                ALIGN_HALF: begin
                    if (is_rvc(hw_q)) begin
                        // Held RVC goes out alone; the fetch port stays closed.
                        core_valid = 1'b1;
                        core_inst  = {16'h0000, hw_q};
                        core_pc    = hw_pc_q;
                        core_err   = hw_err_q;
                        if (core_ready) begin
                            state_d = ALIGN_EMPTY;
                        end
                    end else begin
                        fetch_ready_o = !fetch_valid_i || core_ready;
                        if (fetch_valid_i) begin
                            core_valid = 1'b1;
                            core_pc    = hw_pc_q;
                            if (fw.err) begin
                                core_inst = fw.data;
                                core_err  = 1'b1;
                                if (core_ready) begin
                                    state_d = ALIGN_EMPTY;
                                    halt_d  = 1'b1;
                                end
                            end else begin
                                core_inst = {lo_hw, hw_q};
                                core_err  = hw_err_q;
                                if (core_ready) begin
                                    hw_d     = hi_hw;
                                    hw_pc_d  = pc_plus2;
                                    hw_err_d = 1'b0;
                                end
                            end
                        end
                    end
                end

                ALIGN_SKIP: begin
                    // A non-RVC upper half is parked without any emission,
                    // so that case does not wait on decode.
                    fetch_ready_o = !fetch_valid_i || core_ready ||
                                    (!fw.err && !is_rvc(hi_hw));
                    if (fetch_valid_i) begin
                        if (fw.err) begin
                            core_valid = 1'b1;
                            core_inst  = fw.data;
                            core_pc    = pc_plus2;
                            core_err   = 1'b1;
                            if (core_ready) begin
                                state_d = ALIGN_EMPTY;
                                halt_d  = 1'b1;
                            end
                        end else if (is_rvc(hi_hw)) begin
                            core_valid = 1'b1;
                            core_inst  = {16'h0000, hi_hw};
                            core_pc    = pc_plus2;
                            if (core_ready) begin
                                state_d = ALIGN_EMPTY;
                            end
                        end else begin
                            state_d  = ALIGN_HALF;
                            hw_d     = hi_hw;
                            hw_pc_d  = pc_plus2;
                            hw_err_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = ALIGN_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ALIGN_EMPTY;
            hw_q     <= '0;
            hw_pc_q  <= RESET_PC;
            hw_err_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hw_q     <= hw_d;
            hw_pc_q  <= hw_pc_d;
            hw_err_q <= hw_err_d;
            halt_q   <= halt_d;
        end
    end

`ifdef ALIGN_SKID_EN
    localparam int PAY_W = 32 + XLEN + 1;

    logic [PAY_W-1:0] skid_data;

    inst_aligner_skid #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (flush_i),
        .in_valid_i (core_valid),
        .in_ready_o (core_ready),
        .in_data_i  ({core_inst, core_pc, core_err}),
        .out_valid_o(inst_valid_o),
        .out_ready_i(inst_ready_i),
        .out_data_o (skid_data)
    );

    assign {inst_o, inst_pc_o, inst_err_o} = skid_data;
`else
    assign core_ready   = inst_ready_i;
    assign inst_valid_o = core_valid;
    assign inst_o       = core_inst;
    assign inst_pc_o    = core_pc;
    assign inst_err_o   = core_err;
`endif

    assign inst_is_rvc_o = inst_valid_o && (inst_o[1:0] != 2'b11);

endmodule
